// File: rtl/rf_arb_pkg.sv
// Shared defaults for the register-file writeback arbiter.
// Holds width defaults and the grant-index width helper.
package rf_arb_pkg;

    localparam int NUM_REQ_DEF    = 4;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    // Width of an index into n requesters (never below one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int GRANT_W = idx_w(NUM_REQ_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: search from ptr upward, wrapping.
// Ports: valid, ptr in; one-hot gnt, gnt_idx, any out.
module rr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int N  = NUM_REQ_DEF,
    parameter int GW = idx_w(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [GW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [GW-1:0] gnt_idx,
    output logic          any
);

    int            s;
    logic [GW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        s       = 0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            s = int'(ptr) + k;
            if (s >= N) s = s - N;
            idx = GW'(s);
            if (!any && valid[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/reg_wb_arb.sv
// Round-robin writeback arbiter in front of a register file write port.
// Ports: clk, reset (async, active-low); req_valid/req_ready/req_addr/
// req_data per requester (flat slices); registered wr_en, w_addr, w_data,
// grant_id. Option RF_ARB_ZERO_DROP_EN: writes to address 0 are accepted
// immediately and discarded without taking an arbitration slot.
module reg_wb_arb
    import rf_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic                          wr_en,
    output logic [ADDR_WIDTH-1:0]         w_addr,
    output logic [DATA_WIDTH-1:0]         w_data,
    output logic [idx_w(NUM_REQ)-1:0]     grant_id
);

    localparam int GW = idx_w(NUM_REQ);

    logic [GW-1:0]         ptr;
    logic [NUM_REQ-1:0]    arb_valid;
    logic [NUM_REQ-1:0]    gnt;
    logic [GW-1:0]         gnt_idx;
    logic                  any;
    logic [NUM_REQ-1:0]    drop;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

`ifdef RF_ARB_ZERO_DROP_EN
    // Address-0 writes have no effect, so they skip arbitration.
    always_comb begin
        drop = '0;
        for (int i = 0; i < NUM_REQ; i++)
            drop[i] = req_valid[i] &&
                      (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == '0);
    end
`else
    assign drop = '0;
`endif

    assign arb_valid = req_valid & ~drop;

    rr_arbiter #(
        .N  (NUM_REQ),
        .GW (GW)
    ) u_rr (
        .valid   (arb_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // Ready is suppressed during reset so no handshake completes there.
    assign req_ready = reset ? (gnt | drop) : '0;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            wr_en    <= 1'b0;
            w_addr   <= '0;
            w_data   <= '0;
            grant_id <= '0;
        end else begin
            wr_en <= any;
            if (any) begin
                w_addr   <= sel_addr;
                w_data   <= sel_data;
                grant_id <= gnt_idx;
                ptr      <= (gnt_idx == GW'(NUM_REQ - 1)) ?
                            '0 : gnt_idx + GW'(1);
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_arb.sv
// Scoreboard bench for reg_wb_arb: directed vectors push expected
// writes; a negedge monitor pops and compares on every wr_en.
module tb_reg_wb_arb;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic [1:0]  id;
    } wr_t;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [19:0] req_addr;
    logic [127:0] req_data;
    logic        wr_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [1:0]  grant_id;

    logic [4:0]  ta [4];
    logic [31:0] td [4];

    wr_t exp_q [$];
    int  n_vec;
    int  n_bad;

    reg_wb_arb dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .wr_en     (wr_en),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*5 +: 5]   = ta[i];
            req_data[i*32 +: 32] = td[i];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every write the DUT emits must match the queue head.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (wr_en === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write: got a=%0d d=%h id=%0d expected none",
                             w_addr, w_data, grant_id);
                end else begin
                    e = exp_q.pop_front();
                    if (w_addr !== e.a || w_data !== e.d ||
                        grant_id !== e.id) begin
                        n_bad++;
                        $display("FAIL write: got a=%0d d=%h id=%0d expected a=%0d d=%h id=%0d",
                                 w_addr, w_data, grant_id, e.a, e.d, e.id);
                    end
                end
            end
        end
    end

    // One cycle: drive valid, check ready, queue the expected write.
    task automatic step(input logic [3:0] v, input logic [3:0] er,
                        input int g);
        req_valid = v;
        #1;
        chk("req_ready", {28'd0, req_ready}, {28'd0, er});
        if (g >= 0) exp_q.push_back({ta[g], td[g], 2'(g)});
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        req_valid = 4'b0000;
        reset = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        for (int i = 0; i < 4; i++) begin
            ta[i] = 5'(10 + i);
            td[i] = 32'hA0 + i;
        end
        req_valid = 4'b1111;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready", {28'd0, req_ready}, 0);
        chk("rst_wr_en", {31'd0, wr_en}, 0);
        chk("rst_w_addr", {27'd0, w_addr}, 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_grant_id", {30'd0, grant_id}, 0);
        req_valid = 4'b0000;
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // single request
        ta[0] = 5'd3;
        td[0] = 32'hDEADBEEF;
        step(4'b0001, 4'b0001, 0);
        chk("single_wr_en", {31'd0, wr_en}, 1);
        step(4'b0000, 4'b0000, -1);
        chk("idle_wr_en", {31'd0, wr_en}, 0);
        chk("idle_hold_addr", {27'd0, w_addr}, 3);
        drain();

        // fairness from reset, all held
        rst_pulse();
        for (int i = 0; i < 4; i++) begin
            ta[i] = 5'(10 + i);
            td[i] = 32'h100 + i;
        end
        for (int k = 0; k < 8; k++)
            step(4'b1111, 4'(1 << (k % 4)), k % 4);
        step(4'b0000, 4'b0000, -1);
        drain();

        // wrap: move ptr to 3, then 3 and 0 valid
        step(4'b0100, 4'b0100, 2);
        step(4'b1001, 4'b1000, 3);
        step(4'b0001, 4'b0001, 0);
        step(4'b0011, 4'b0010, 1);
        step(4'b0001, 4'b0001, 0);
        step(4'b0000, 4'b0000, -1);
        drain();

        // same address, grant order
        rst_pulse();
        ta[1] = 5'd7;
        td[1] = 32'h11;
        ta[2] = 5'd7;
        td[2] = 32'h22;
        step(4'b0110, 4'b0010, 1);
        step(4'b0100, 4'b0100, 2);
        step(4'b0000, 4'b0000, -1);
        drain();

        // reset between edges while writing
        rst_pulse();
        step(4'b1111, 4'b0001, -1);
        chk("pre_rst_wr_en", {31'd0, wr_en}, 1);
        req_valid = 4'b0110;
        reset = 1'b0;
        #1;
        chk("async_wr_en", {31'd0, wr_en}, 0);
        chk("async_ready", {28'd0, req_ready}, 0);
        chk("async_w_addr", {27'd0, w_addr}, 0);
        chk("async_w_data", w_data, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        step(4'b0110, 4'b0010, 1);
        step(4'b0100, 4'b0100, 2);
        step(4'b0000, 4'b0000, -1);
        drain();

        // address-0 handling (ptr is 3 here)
        ta[0] = 5'd0;
        td[0] = 32'hBAD0;
        ta[1] = 5'd5;
        td[1] = 32'h55;
`ifdef RF_ARB_ZERO_DROP_EN
        step(4'b0011, 4'b0011, 1);
`else
        step(4'b0011, 4'b0001, 0);
        step(4'b0010, 4'b0010, 1);
`endif
        step(4'b0000, 4'b0000, -1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_wb_arb.md
REG_WB_ARB -- requirements
Module: reg_wb_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of writeback requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bits per register.
REQ-003 SHALL have parameter ADDR_WIDTH, default 5, register address bits.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester write request.
REQ-007 SHALL have port req_ready  output  NUM_REQ  per-requester accept.
REQ-008 SHALL have port req_addr  input  NUM_REQ*ADDR_WIDTH  flat destination addresses; requester i at slice i.
REQ-009 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  flat write data; requester i at slice i.
REQ-010 SHALL have port wr_en  output  1  register-file write enable.
REQ-011 SHALL have port w_addr  output  ADDR_WIDTH  register-file write address.
REQ-012 SHALL have port w_data  output  DATA_WIDTH  register-file write data.
REQ-013 SHALL have port grant_id  output  clog2(NUM_REQ)  index of the requester that produced the current wr_en.

Function
REQ-014 SHALL accept at most one arbitrated request per cycle; transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-015 SHALL drive req_ready combinationally: 1 only for the round-robin winner among valid requesters; 0 for all others.
REQ-016 SHALL grant round-robin: search starts at index ptr, wraps from NUM_REQ-1 to 0; after a grant to i, ptr becomes (i+1) mod NUM_REQ.
REQ-017 SHALL hold ptr unchanged in cycles with no transfer.
REQ-018 SHALL register the accepted request: wr_en, w_addr, w_data and grant_id update on the edge of the transfer; latency from handshake to wr_en is 1 cycle.
REQ-019 SHALL drive wr_en 0 in any cycle following a cycle with no transfer; w_addr, w_data, grant_id hold their last values.
REQ-020 SHALL serialize same-address requests in grant order; the later grant's data is written last.
REQ-021 SHALL require requesters to hold req_valid, addr and data stable until accepted; the block does not buffer unaccepted requests.
REQ-022 SHALL sustain one write per cycle while any requester is valid (no bubbles).

Reset
REQ-023 SHALL, while reset is 0, immediately force wr_en=0, w_addr=0, w_data=0, grant_id=0, ptr=0.
REQ-024 SHALL drive req_ready all 0 while reset is 0; a handshake in progress is discarded.
REQ-025 SHALL resume arbitration from index 0 on the first rising clk edge after reset deasserts.

Configuration
REQ-026 SHALL, with macro RF_ARB_ZERO_DROP_EN defined, assert req_ready for every valid requester with address 0 in the same cycle, excluded from arbitration, producing no wr_en and not moving ptr.
REQ-027 SHALL, without RF_ARB_ZERO_DROP_EN, arbitrate address-0 requests normally and emit wr_en with w_addr=0.

Structure
REQ-028 SHALL place default DATA_WIDTH, ADDR_WIDTH, NUM_REQ and the grant-index width constant in shared package rf_arb_pkg.
REQ-029 SHALL isolate combinational round-robin grant logic (valid vector, ptr -> one-hot grant) in sub-module rr_arbiter; reg_wb_arb holds ptr and output registers.

Verification
REQ-030 SHALL verify single request: req_valid=0001, addr0=3, data0=0xDEADBEEF -> req_ready=0001; next cycle wr_en=1, w_addr=3, w_data=0xDEADBEEF, grant_id=0.
REQ-031 SHALL verify fairness: all four valid and held for 8 cycles from reset -> grant_id sequence 0,1,2,3,0,1,2,3, wr_en=1 every cycle.
REQ-032 SHALL verify wrap: ptr=3, valid=1001 -> grant 3 then 0; ptr ends at 1.
REQ-033 SHALL verify same-address ordering: requesters 1 and 2 both addr 7, data 0x11 and 0x22, ptr=0 -> writes 0x11 then 0x22 to register 7.
REQ-034 SHALL verify mid-operation reset: reset to 0 between clk edges while wr_en=1 -> wr_en=0 and req_ready=0000 without a clock edge; first grant after release goes to lowest valid index.
REQ-035 SHALL verify zero drop with RF_ARB_ZERO_DROP_EN: valid=0011, addr0=0, addr1=5 -> req_ready=0011, single wr_en with w_addr=5; without macro, two writes over two cycles, addresses 0 then 5.
